// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit.
// A radix-2 shift-add multiplier and a restoring divider share one 64-bit
// working register. Operands are reduced to magnitudes at accept time, the
// loop runs for XLEN edges, and a final FIX edge applies the recorded sign.
// Divide-by-zero and signed overflow may bypass the loop (EARLY_OUT).
// Only XLEN=32 is supported.
module mdu_iter #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]     cnt;
    logic [2:0]        op;        // latched funct3
    logic              res_neg;   // negate the selected output in FIX
    logic [XLEN-1:0]   opb;       // multiplicand / divisor magnitude
    logic [2*XLEN-1:0] work;      // {hi, lo}: product or {remainder, quotient}

    // ---------------------------------------------------------------
    // Accept-time operand decode (only used on the start edge)
    // ---------------------------------------------------------------
    logic            accept;
    logic            is_div_in;
    logic            sgn_a_in, sgn_b_in;
    logic            sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            b_zero, ovf;
    logic            neg_in;
    logic            early;
    logic [XLEN-1:0] early_val;

    assign accept    = start && (state == IDLE);
    assign is_div_in = funct3[2];

    // MUL/MULH/MULHSU treat rs1 as signed, MUL/MULH treat rs2 as signed;
    // DIV/REM are signed on both, the U variants on neither.
    assign sgn_a_in  = is_div_in ? ~funct3[0] : (funct3 != 3'b011);
    assign sgn_b_in  = is_div_in ? ~funct3[0] : ~funct3[1];

    assign sa        = sgn_a_in & op_a[XLEN-1];
    assign sb        = sgn_b_in & op_b[XLEN-1];
    assign mag_a     = sa ? (~op_a + 1'b1) : op_a;
    assign mag_b     = sb ? (~op_b + 1'b1) : op_b;

    assign b_zero    = (op_b == '0);
    assign ovf       = is_div_in && !funct3[0]
                       && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                       && (op_b == '1);

    // Quotient of x/0 is all ones regardless of sign, so its sign is
    // suppressed; remainder always takes the dividend's sign.
    assign neg_in    = !is_div_in ? (sa ^ sb)
                     : funct3[1]  ? sa
                     :              ((sa ^ sb) & ~b_zero);

    assign early     = EARLY_OUT && is_div_in && (b_zero || ovf);
    assign early_val = !funct3[1] ? (b_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}})
                     :              (b_zero ? op_a : '0);

    // ---------------------------------------------------------------
    // One iteration of the shared datapath
    // ---------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic              fits;
    logic [XLEN-1:0]   diff;
    logic [2*XLEN-1:0] div_next;

    assign mul_sum  = {1'b0, work[2*XLEN-1:XLEN]}
                    + (work[0] ? {1'b0, opb} : '0);
    assign mul_next = {mul_sum, work[XLEN-1:1]};

    // The shifted partial remainder can need XLEN+1 bits; the difference
    // is only kept when it is below the divisor, so XLEN bits suffice.
    assign rem_sh   = work[2*XLEN-1:XLEN-1];
    assign fits     = (rem_sh >= {1'b0, opb});
    assign diff     = rem_sh[XLEN-1:0] - opb;
    assign div_next = fits ? {diff, work[XLEN-2:0], 1'b1}
                           : {work[2*XLEN-2:0], 1'b0};

    // Sign fix-up and output selection for the FIX edge
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_val;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        fix_val  = '0;
        prod_fix = res_neg ? (~work + 1'b1) : work;
        case (op)
            3'b000:  fix_val = prod_fix[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100,
            3'b101:  fix_val = res_neg ? (~work[XLEN-1:0] + 1'b1)
                                       : work[XLEN-1:0];
            default: fix_val = res_neg ? (~work[2*XLEN-1:XLEN] + 1'b1)
                                       : work[2*XLEN-1:XLEN];
        endcase
    end

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = early ? DONE : CALC;
            CALC:    if (cnt == LAST) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            op      <= '0;
            res_neg <= 1'b0;
            opb     <= '0;
            work    <= '0;
            result  <= '0;
            rd_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op      <= funct3;
                        rd_out  <= rd_in;
                        res_neg <= neg_in;
                        cnt     <= '0;
                        opb     <= mag_b;
                        work    <= {{XLEN{1'b0}}, mag_a};
                        if (early) result <= early_val;
                    end
                end
                CALC: begin
                    work <= op[2] ? div_next : mul_next;
                    cnt  <= cnt + 1'b1;
                end
                FIX:     result <= fix_val;
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit for the single-cycle core.
- Consumes the register-file read data (rd1/rd2) for M-extension instructions and stalls the core while it runs.
- Its result and destination tag drive the register-file write port (wd3/Addr3/we3) for one cycle.
- Radix-2 shift-add multiplier and restoring divider share one 64-bit working register.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- EARLY_OUT, 1, when 1 divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when busy=0.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (from rd1).
- op_b  in  XLEN  rs2 value (from rd2).
- rd_in  in  5  destination register index.
- busy  out  1  high in any state except IDLE; core stalls on it.
- done  out  1  one-cycle pulse; result/rd_out valid; drives we3.
- result  out  XLEN  registered result; held until next accepted start.
- rd_out  out  5  latched rd_in; drives Addr3.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, busy=0, done=0, result=0, rd_out=0.
  - Iteration counter=0; all working registers=0.
  - Applies from any state, including mid-CALC; an aborted operation never asserts done.
- IDLE:
  - start=1 at edge E0 latches funct3, rd_in, and op_a/op_b.
  - Operands are converted to magnitudes per signedness:
    - MULH: both signed.
    - MULHSU: op_a signed, op_b unsigned.
    - MULHU, DIVU, REMU: both unsigned.
    - DIV, REM: both signed.
  - Result sign is recorded: product sign, or quotient sign = sa^sb, or remainder sign = sign of op_a.
  - Next state is CALC with counter=0.
  - Inputs are not sampled again until the next accepted start.
- Early-out (EARLY_OUT=1), checked at E0 for DIV/DIVU/REM/REMU; next state is DONE directly:
  - op_b=0: quotient = all ones; remainder = op_a.
  - Signed DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
  - done is asserted in the cycle after E0.
  - With EARLY_OUT=0 these cases iterate and FIX still yields the same values.
- CALC: exactly 32 edges (E1..E32), one bit per edge.
  - Multiply: if multiplier LSB=1, add multiplicand into the upper half; shift right 1 (33-bit carry kept).
  - Divide: shift the {rem,quot} pair left 1; trial-subtract the divisor; if no borrow, keep the difference and set quotient LSB=1.
  - Counter increments each edge; after counter=31, next state is FIX.
- FIX (one edge, E33):
  - Apply two's-complement negation if the recorded sign is set.
  - Select the output:
    - MUL: low 32 bits.
    - MULH/MULHSU/MULHU: high 32 bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the selection into result.
  - Next state is DONE.
- DONE:
  - done=1 for exactly one cycle; next state is IDLE.
  - Normal latency: done is high during the cycle after E33, i.e. 34 cycles after the start edge.
- busy=1 throughout CALC, FIX, and DONE.
  - start during busy, including the DONE cycle, is ignored and not queued.
  - A new start is accepted no earlier than the first IDLE cycle.
- Operand changes while busy do not affect result.
- result and rd_out hold their values until the next accepted start.
- Back-to-back operations: minimum issue interval is 35 cycles (2 with early-out).

Test Plan:
- MUL: op_a=7, op_b=0xFFFFFFFD, funct3=000, rd_in=5 -> result=0xFFFFFFEB, rd_out=5; done high exactly 34 cycles after start edge for one cycle; busy low the following cycle.
- MULH family:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
  - MULH 0x7FFFFFFF*2 -> 0x00000000.
- Divide/remainder:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
  - REM 0xFFFFFFF9/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
  - DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
- Corner cases (EARLY_OUT=1; done one cycle after start):
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
  - Repeat all with EARLY_OUT=0 -> same values after 34 cycles.
- Handshake: start again at cycles 5 and 34 (DONE) of a MUL with different operands/rd_in -> ignored; result and rd_out from the first op; done pulses once.
- Reset: drive rst=0 at cycle 10 of CALC -> busy, done, result, rd_out =0 immediately (before next edge); release, issue DIVU 9/3 -> result=3 after 34 cycles.
